// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter that shares one registered-address sprite ROM among
// several row fetchers. A granted requester may hold the ROM for a bounded
// burst. Each grant comes back two cycles later as a tagged, registered row.
module sprite_rom_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 51,
  parameter int ROW_COUNT = 60,
  parameter int MAX_BURST = 16,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_row,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_data,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ARB_RR     = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  arb_state_t        state_reg, state_next;
  logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0]   owner_reg, owner_next;
  logic [CNT_W-1:0]  burst_cnt_reg, burst_cnt_next;
  logic [ADDR_W-1:0] addr_hold_reg;

  logic              s1_valid_reg;
  logic [ID_W-1:0]   s1_id_reg;
  logic              s1_oor_reg;

  logic              hold;
  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [ADDR_W-1:0] row_sel;
  logic              row_oor;
  logic [NUM_REQ-1:0] gnt_raw;

  logic [ADDR_W-1:0] row_arr [NUM_REQ];

  // Unpack the per-requester row addresses and build the one-hot grant.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign row_arr[gi] = req_row[gi*ADDR_W +: ADDR_W];
    assign gnt_raw[gi] = win_found && (win_id == ID_W'(gi));
  end

  // Winner selection: a live lock owner wins outright, otherwise scan upward
  // from the slot after the last winner.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    hold      = (state_reg == ARB_LOCKED) && req[owner_reg] && req_lock[owner_reg];
    if (hold) begin
      win_found = 1'b1;
      win_id    = owner_reg;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (int'(rr_ptr_reg) + k) % NUM_REQ;
        if (!win_found && req[idx]) begin
          win_found = 1'b1;
          win_id    = ID_W'(idx);
        end
      end
    end
  end

  assign row_sel = row_arr[win_id];
  assign row_oor = ({{(32-ADDR_W){1'b0}}, row_sel} >= 32'(ROW_COUNT));

  // Grant and address are forced to zero while reset is held; with no winner
  // the address keeps its previous value so the ROM output stays stable.
  assign gnt         = rst ? '0 : gnt_raw;
  assign rom_address = rst ? '0 : (win_found ? row_sel : addr_hold_reg);
  assign busy        = s1_valid_reg || rsp_valid;

  // Lock state machine, burst counter and round-robin pointer next state.
  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    burst_cnt_next = burst_cnt_reg;
    rr_ptr_next    = rr_ptr_reg;
    if (hold) begin
      burst_cnt_next = burst_cnt_reg + 1'b1;
      if (burst_cnt_reg == CNT_W'(MAX_BURST - 1)) begin
        // This grant is the last one of the burst.
        state_next     = ARB_RR;
        burst_cnt_next = '0;
        rr_ptr_next    = owner_reg;
      end
    end else begin
      state_next     = ARB_RR;
      burst_cnt_next = '0;
      if (state_reg == ARB_LOCKED) begin
        rr_ptr_next = owner_reg;
      end
      if (win_found) begin
        rr_ptr_next = win_id;
        if (req_lock[win_id]) begin
          state_next     = ARB_LOCKED;
          owner_next     = win_id;
          burst_cnt_next = CNT_W'(1);
        end
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ARB_RR;
      owner_reg     <= '0;
      burst_cnt_reg <= '0;
      rr_ptr_reg    <= ID_W'(NUM_REQ - 1);
      addr_hold_reg <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      burst_cnt_reg <= burst_cnt_next;
      rr_ptr_reg    <= rr_ptr_next;
      if (win_found) begin
        addr_hold_reg <= row_sel;
      end
    end
  end

  // Stage 1: remember who was granted and whether the row is out of range
  // while the ROM registers the address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_id_reg    <= '0;
      s1_oor_reg   <= 1'b0;
    end else begin
      s1_valid_reg <= win_found;
      if (win_found) begin
        s1_id_reg  <= win_id;
        s1_oor_reg <= row_oor;
      end
    end
  end

  // Stage 2: capture the ROM row with its tag; data holds between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= s1_valid_reg;
      if (s1_valid_reg) begin
        rsp_id   <= s1_id_reg;
        rsp_data <= s1_oor_reg ? '0 : rom_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: a vector table for single reads,
// round-robin and out-of-range rows, then hand sequences for burst lock,
// a full row sweep and reset in the middle of a read.
module tb_sprite_rom_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 51;
  localparam int ID_W    = 2;
  localparam int NVEC    = 14;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_row;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rom_address;
  logic [DATA_W-1:0]         rom_data;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      busy;

  int total;
  int bad;

  typedef struct {
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ*ADDR_W-1:0] rows;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         addr;
    logic                      rv;
    logic [ID_W-1:0]           rid;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;
  } vec_t;

  vec_t vec [NVEC];

  sprite_rom_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .ROW_COUNT(60), .MAX_BURST(16)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_lock(req_lock), .req_row(req_row),
    .gnt(gnt), .rom_address(rom_address), .rom_data(rom_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sprite ROM contents: row 15 all ones, rows 0 and 59 only bit 25,
  // other valid rows carry their index above bit 25, rows past 59 are junk.
  function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] r);
    logic [DATA_W-1:0] d;
    if (r == 6'd15)                  d = {DATA_W{1'b1}};
    else if (r == 6'd0 || r == 6'd59) d = DATA_W'(1) << 25;
    else if (r < 6'd60)              d = (DATA_W'(r) << 26) | (DATA_W'(1) << 25);
    else                             d = 51'h5A5A5A5A5A5A5;
    return d;
  endfunction

  // ROM model with registered address, one-cycle latency.
  always @(posedge clk) rom_data <= rom_fn(rom_address);

  function automatic logic [NUM_REQ*ADDR_W-1:0] pack(input int r0, input int r1,
                                                      input int r2, input int r3);
    return {ADDR_W'(r3), ADDR_W'(r2), ADDR_W'(r1), ADDR_W'(r0)};
  endfunction

  function automatic vec_t mk(input logic [3:0] rq, input logic [NUM_REQ*ADDR_W-1:0] rows,
                              input logic [3:0] g, input int addr, input logic rv,
                              input int rid, input logic [DATA_W-1:0] rd, input logic bz);
    vec_t v;
    v.req = rq; v.lock = 4'b0000; v.rows = rows; v.gnt = g;
    v.addr = ADDR_W'(addr); v.rv = rv; v.rid = ID_W'(rid); v.rdata = rd; v.busy = bz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l,
                       input logic [NUM_REQ*ADDR_W-1:0] rows);
    @(negedge clk);
    req = r; req_lock = l; req_row = rows;
    #1;
  endtask

  initial begin
    logic [DATA_W-1:0] ones;
    logic [NUM_REQ*ADDR_W-1:0] r1234;
    ones  = {DATA_W{1'b1}};
    r1234 = pack(1, 2, 3, 4);
    total = 0;
    bad   = 0;

    //          req      rows              gnt      addr rv  id data         busy
    vec[0]  = mk(4'b0000, '0,               4'b0000, 0,  0, 0, '0,          0);
    vec[1]  = mk(4'b0001, pack(15,0,0,0),   4'b0001, 15, 0, 0, '0,          0);
    vec[2]  = mk(4'b0000, '0,               4'b0000, 15, 0, 0, '0,          1);
    vec[3]  = mk(4'b0000, '0,               4'b0000, 15, 1, 0, ones,        1);
    vec[4]  = mk(4'b1111, r1234,            4'b0010, 2,  0, 0, ones,        0);
    vec[5]  = mk(4'b1111, r1234,            4'b0100, 3,  0, 0, ones,        1);
    vec[6]  = mk(4'b1111, r1234,            4'b1000, 4,  1, 1, rom_fn(2),   1);
    vec[7]  = mk(4'b1111, r1234,            4'b0001, 1,  1, 2, rom_fn(3),   1);
    vec[8]  = mk(4'b1111, r1234,            4'b0010, 2,  1, 3, rom_fn(4),   1);
    vec[9]  = mk(4'b1111, r1234,            4'b0100, 3,  1, 0, rom_fn(1),   1);
    vec[10] = mk(4'b0100, pack(0,0,62,0),   4'b0100, 62, 1, 1, rom_fn(2),   1);
    vec[11] = mk(4'b0000, '0,               4'b0000, 62, 1, 2, rom_fn(3),   1);
    vec[12] = mk(4'b0000, '0,               4'b0000, 62, 1, 2, '0,          1);
    vec[13] = mk(4'b0000, '0,               4'b0000, 62, 0, 2, '0,          0);

    // Reset state, with requests present to show grant gating.
    rst = 1'b1; req = 4'b1111; req_lock = '0; req_row = pack(9, 9, 9, 9);
    #12;
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_addr", 64'(rom_address), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst = 1'b0; req = '0;

    // Table-driven: single read, round-robin, out-of-range row.
    for (int i = 0; i < NVEC; i++) begin
      drive(vec[i].req, vec[i].lock, vec[i].rows);
      $display("vec %0d: req=%b gnt=%b addr=%0d rsp_valid=%b rsp_id=%0d busy=%b",
               i, vec[i].req, gnt, rom_address, rsp_valid, rsp_id, busy);
      chk($sformatf("vec%0d_gnt", i), 64'(gnt), 64'(vec[i].gnt));
      chk($sformatf("vec%0d_addr", i), 64'(rom_address), 64'(vec[i].addr));
      chk($sformatf("vec%0d_rsp_valid", i), 64'(rsp_valid), 64'(vec[i].rv));
      chk($sformatf("vec%0d_rsp_id", i), 64'(rsp_id), 64'(vec[i].rid));
      chk($sformatf("vec%0d_rsp_data", i), 64'(rsp_data), 64'(vec[i].rdata));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vec[i].busy));
    end

    // Burst lock: requester 1 locks and keeps the ROM for 16 grants even
    // though requester 0 is asking, then requester 0 is served.
    drive(4'b0010, 4'b0010, pack(1, 2, 3, 4));
    chk("lock_first", 64'(gnt), 64'(4'b0010));
    for (int i = 1; i < 16; i++) begin
      drive(4'b0011, 4'b0010, pack(1, 2, 3, 4));
      chk($sformatf("lock_burst%0d", i), 64'(gnt), 64'(4'b0010));
    end
    drive(4'b0011, 4'b0010, pack(1, 2, 3, 4));
    chk("lock_release_max", 64'(gnt), 64'(4'b0001));
    $display("burst: 16 grants to requester 1 then requester 0");

    // Lock again, drop the hint after 3 grants: release to requester 0.
    for (int i = 0; i < 3; i++) begin
      drive(4'b0011, 4'b0010, pack(1, 2, 3, 4));
      chk($sformatf("lock_short%0d", i), 64'(gnt), 64'(4'b0010));
    end
    drive(4'b0011, 4'b0000, pack(1, 2, 3, 4));
    chk("lock_release_hint", 64'(gnt), 64'(4'b0001));
    $display("burst: hint dropped after 3 grants, requester 0 served");

    // Drain, then sweep every valid row from requester 0.
    for (int i = 0; i < 3; i++) drive(4'b0000, 4'b0000, '0);
    for (int i = 0; i < 62; i++) begin
      if (i < 60) drive(4'b0001, 4'b0000, pack(i, 0, 0, 0));
      else        drive(4'b0000, 4'b0000, '0);
      chk($sformatf("sweep%0d_gnt", i), 64'(gnt), 64'(i < 60 ? 4'b0001 : 4'b0000));
      chk($sformatf("sweep%0d_rsp_valid", i), 64'(rsp_valid), 64'(i >= 2));
      if (i >= 2) begin
        chk($sformatf("sweep%0d_rsp_data", i), 64'(rsp_data), 64'(rom_fn(ADDR_W'(i - 2))));
        chk($sformatf("sweep%0d_rsp_id", i), 64'(rsp_id), 64'(0));
        $display("sweep row %0d: rsp_data=%0h", i - 2, rsp_data);
      end
    end
    drive(4'b0000, 4'b0000, '0);
    chk("sweep_row59_data", 64'(rsp_data), 64'(51'h2000000));
    chk("sweep_end_valid", 64'(rsp_valid), 64'(0));
    drive(4'b0000, 4'b0000, '0);

    // Reset with one response out and one in stage 1.
    drive(4'b0100, 4'b0000, pack(0, 0, 5, 0));
    chk("mid_gnt2", 64'(gnt), 64'(4'b0100));
    drive(4'b1000, 4'b0000, pack(0, 0, 0, 7));
    chk("mid_gnt3", 64'(gnt), 64'(4'b1000));
    drive(4'b0000, 4'b0000, '0);
    chk("mid_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("mid_rsp_id", 64'(rsp_id), 64'(2));
    #2;
    rst = 1'b1; req = 4'b1111;
    #1;
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_gnt", 64'(gnt), 64'(0));
    chk("mid_rst_addr", 64'(rom_address), 64'(0));
    @(negedge clk);
    rst = 1'b0; req = '0;
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 4'b0000, '0);
      chk($sformatf("post_rst%0d_rsp_valid", i), 64'(rsp_valid), 64'(0));
    end
    drive(4'b1111, 4'b0000, pack(1, 2, 3, 4));
    chk("post_rst_first_gnt", 64'(gnt), 64'(4'b0001));
    $display("reset mid-flight: first grant after reset gnt=%b", gnt);
    drive(4'b0000, 4'b0000, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
Shares one registered-address sprite ROM (6-bit row address, 51-bit row, 60 valid rows, 1-cycle read latency) between up to NUM_REQ requesters, e.g. several pipe/obstacle renderers fetching sprite rows during horizontal blanking.
- Arbitration is round-robin, with an optional bounded burst lock.
- Returns tagged, registered row data.
- Sits between the renderers and the sprite ROM instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 6, ROM row address width
DATA_W, 51, ROM row width
ROW_COUNT, 60, number of valid rows; rows >= ROW_COUNT read as zero
MAX_BURST, 16, max consecutive grants to one locked requester (2..64)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
req  input  NUM_REQ  per-requester read request, level
req_lock  input  NUM_REQ  per-requester burst lock hint
req_row  input  NUM_REQ*ADDR_W  packed row addresses; requester i at bits [i*ADDR_W +: ADDR_W]
gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as selection
rom_address  output  ADDR_W  row address to sprite ROM (ROM registers it internally)
rom_data  input  DATA_W  ROM row output, valid 1 cycle after rom_address
rsp_valid  output  1  response valid, registered
rsp_id  output  clog2(NUM_REQ)  index of requester owning rsp_data
rsp_data  output  DATA_W  returned row, registered
busy  output  1  high while any read is in flight (stage1 or stage2 valid)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values while rst=1:
  - gnt=0 and rom_address=0 (gated combinationally).
  - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has top priority first.
  - Lock state cleared, burst counter=0; both pipeline stages invalid.
- Arbitration, cycle T:
  - Winner is the first requester with req=1 scanning from rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - gnt[winner]=1 and rom_address=req_row[winner].
  - No req: gnt=0 and rom_address holds its last driven value, so the ROM output is stable.
  - Requester i treats gnt[i]=1 at the edge ending T as consumed; it may change req_row/req in T+1.
- Pointer update: on every grant, rr_ptr<=winner unless a lock is active.
- Lock:
  - Triggered when the granted requester has req_lock=1: lock_owner<=winner, burst_cnt<=1.
  - While locked, the owner wins whenever its req=1, even if others request; burst_cnt increments per grant.
  - Lock releases when any of these holds: the owner's req=0 or req_lock=0 in a cycle, or burst_cnt reaches MAX_BURST (that grant is the last).
  - On release, rr_ptr<=owner, so other requesters are served next.
- Pipeline:
  - Stage1 (edge ending T): s1_valid<=|gnt, s1_id<=winner, s1_oor<=(row>=ROW_COUNT).
  - Stage2 (edge ending T+1): rsp_valid<=s1_valid, rsp_id<=s1_id, rsp_data<=s1_oor ? 0 : rom_data.
  - Total latency: grant in cycle T gives rsp_valid=1 in cycle T+2.
  - Throughput: one grant per cycle, back-to-back, no bubbles.
- rsp_valid is a single-cycle pulse per grant. No backpressure: consumers must accept in that cycle.
- rsp_data holds its last value when rsp_valid=0.
- Out-of-range row: still granted and still takes one slot; returns all-zero data regardless of rom_data.
- Simultaneous events:
  - A lock release and a new request in the same cycle: the new selection uses the updated pointer from the next cycle.
  - A requester dropping req in the same cycle it would win is simply not granted.
- Reset mid-operation: in-flight stage1/stage2 entries are discarded; no rsp_valid after rst deasserts for grants issued before reset.

Test Plan:
1. Single read: req=0001, req_row[0]=15, rom returns all-ones for row 15 -> gnt=0001 in T, rsp_valid=1, rsp_id=0, rsp_data=51'h7FFFFFFFFFFFF in T+2, busy high T+1..T+2.
2. Round-robin fairness: req=1111 held 8 cycles, no lock -> gnt sequence 0001,0010,0100,1000,0001,... and rsp_id 0,1,2,3,0,... two cycles later.
3. Burst lock: req=0011, req_lock[1]=1, requester 1 granted first -> requester 1 gets MAX_BURST=16 consecutive grants, then requester 0 granted. Repeat with req_lock[1] dropped after 3 grants -> release after 3.
4. Out of range: req_row[2]=62 while ROM drives nonzero -> rsp_data=0, rsp_id=2, one slot consumed.
5. Back-to-back rows: requester 0 sweeps rows 0..59 continuously -> 60 consecutive rsp_valid pulses with data in row order; row 0 has only bit 25 set, row 59 likewise.
6. Async reset mid-flight: assert rst between grant and response -> rsp_valid falls immediately, no stale response after release, and the first grant after reset goes to requester 0.
